peripheral_bridge: RTL and testbench

PERIPHERAL_BRIDGE -- requirements
Module: peripheral_bridge

---
 rtl/peripheral_bridge.sv | 126 ++++++++++++
 tb/tb_peripheral_bridge.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bridge.sv
// CPU-to-peripheral bridge: decodes one of four slots, issues a single shared command,
// waits for the slot's ready pulse (or times out) and returns a one-cycle CPU response.
module peripheral_bridge #(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [3:0]  SLOT_ENABLE = 4'b1111
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_cpu_request,
  input  logic         i_cpu_rw,
  input  logic [9:0]   i_cpu_address,
  input  logic [31:0]  i_cpu_wdata,
  output logic [31:0]  o_cpu_rdata,
  output logic         o_cpu_ready,
  output logic         o_cpu_error,
  output logic [3:0]   o_pb_request,
  output logic         o_pb_rw,
  output logic [5:0]   o_pb_address,
  output logic [31:0]  o_pb_wdata,
  input  logic [3:0]   i_pb_ready,
  input  logic [127:0] i_pb_rdata
);

  localparam logic [15:0] LastCount = 16'(TIMEOUT - 1);
  localparam logic [31:0] ErrorData = 32'hDEADBEEF;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic        pb_rw_q, pb_rw_d;
  logic [5:0]  pb_address_q, pb_address_d;
  logic [31:0] pb_wdata_q, pb_wdata_d;
  logic [15:0] count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        slot_ready;
  logic [31:0] slot_rdata;
  logic        unused_addr;

  assign unused_addr = ^i_cpu_address[1:0];
  assign slot_ready  = i_pb_ready[slot_q];
  assign slot_rdata  = i_pb_rdata[{slot_q, 5'b00000} +: 32];

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    pb_rw_d      = pb_rw_q;
    pb_address_d = pb_address_q;
    pb_wdata_d   = pb_wdata_q;
    count_d      = count_q;
    rdata_d      = rdata_q;
    error_d      = error_q;
    case (state_q)
      StIdle: begin
        if (i_cpu_request) begin
          slot_d       = i_cpu_address[9:8];
          pb_rw_d      = i_cpu_rw;
          pb_address_d = i_cpu_address[7:2];
          pb_wdata_d   = i_cpu_wdata;
          count_d      = 16'd0;
          if (SLOT_ENABLE[i_cpu_address[9:8]]) begin
            state_d = StWait;
          end else begin
            state_d = StResp;
            rdata_d = ErrorData;
            error_d = 1'b1;
          end
        end
      end
      StWait: begin
        // Ready takes precedence over a timeout landing on the same edge.
        if (slot_ready) begin
          rdata_d = pb_rw_q ? 32'd0 : slot_rdata;
          error_d = 1'b0;
          state_d = StResp;
        end else if (count_q == LastCount) begin
          rdata_d = ErrorData;
          error_d = 1'b1;
          state_d = StResp;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StIdle;
      slot_q       <= 2'd0;
      pb_rw_q      <= 1'b0;
      pb_address_q <= 6'd0;
      pb_wdata_q   <= 32'd0;
      count_q      <= 16'd0;
      rdata_q      <= 32'd0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      pb_rw_q      <= pb_rw_d;
      pb_address_q <= pb_address_d;
      pb_wdata_q   <= pb_wdata_d;
      count_q      <= count_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
    end
  end

  // Request drops in the ready cycle so a single-cycle peripheral sees one request edge.
  always_comb begin
    o_pb_request = 4'b0000;
    if (state_q == StWait && !slot_ready) o_pb_request = 4'b0001 << slot_q;
  end

  assign o_cpu_ready  = (state_q == StResp);
  assign o_cpu_error  = o_cpu_ready & error_q;
  assign o_cpu_rdata  = rdata_q;
  assign o_pb_rw      = pb_rw_q;
  assign o_pb_address = pb_address_q;
  assign o_pb_wdata   = pb_wdata_q;

endmodule

// File: tb/tb_peripheral_bridge.sv
// Scoreboard bench for peripheral_bridge (TIMEOUT=8, slot 3 unpopulated).
module tb_peripheral_bridge;

  logic         clk;
  logic         i_reset;
  logic         i_cpu_request;
  logic         i_cpu_rw;
  logic [9:0]   i_cpu_address;
  logic [31:0]  i_cpu_wdata;
  logic [31:0]  o_cpu_rdata;
  logic         o_cpu_ready;
  logic         o_cpu_error;
  logic [3:0]   o_pb_request;
  logic         o_pb_rw;
  logic [5:0]   o_pb_address;
  logic [31:0]  o_pb_wdata;
  logic [3:0]   i_pb_ready;
  logic [127:0] i_pb_rdata;

  peripheral_bridge #(
    .TIMEOUT    (8),
    .SLOT_ENABLE(4'b0111)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_cpu_request(i_cpu_request),
    .i_cpu_rw     (i_cpu_rw),
    .i_cpu_address(i_cpu_address),
    .i_cpu_wdata  (i_cpu_wdata),
    .o_cpu_rdata  (o_cpu_rdata),
    .o_cpu_ready  (o_cpu_ready),
    .o_cpu_error  (o_cpu_error),
    .o_pb_request (o_pb_request),
    .o_pb_rw      (o_pb_rw),
    .o_pb_address (o_pb_address),
    .o_pb_wdata   (o_pb_wdata),
    .i_pb_ready   (i_pb_ready),
    .i_pb_rdata   (i_pb_rdata)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rdy_count;
  int          pb_cycles [4];
  int          rise_cyc, ready_cyc, start_cyc;
  logic        prev_req = 1'b0;
  logic [31:0] last_rdata = 32'd0;
  logic [32:0] exp_q [$];
  logic        exp_pb_rw;
  logic [5:0]  exp_pb_address;
  logic [31:0] exp_pb_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pop on each CPU response, command-bus and hold checks.
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (o_cpu_ready) begin
      rdy_count++;
      ready_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ready", {31'd0, o_cpu_ready}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("cpu_rdata", o_cpu_rdata, e[31:0]);
        check_eq("cpu_error", {31'd0, o_cpu_error}, {31'd0, e[32]});
        last_rdata = e[31:0];
      end
    end else if (!i_reset) begin
      check_eq("rdata_hold", o_cpu_rdata, last_rdata);
    end
    if (o_pb_request != 4'b0000) begin
      check_eq("pb_rw", {31'd0, o_pb_rw}, {31'd0, exp_pb_rw});
      check_eq("pb_address", {26'd0, o_pb_address}, {26'd0, exp_pb_address});
      check_eq("pb_wdata", o_pb_wdata, exp_pb_wdata);
      if (!prev_req) rise_cyc = cyc;
      for (int i = 0; i < 4; i++) pb_cycles[i] += int'(o_pb_request[i]);
    end
    prev_req = (o_pb_request != 4'b0000);
  end

  task automatic clear_counts();
    rdy_count = 0;
    for (int i = 0; i < 4; i++) pb_cycles[i] = 0;
  endtask

  task automatic wait_cpu_ready();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_cpu_ready && t < 60);
    if (!o_cpu_ready) check_eq("cpu_ready_bound", {31'd0, o_cpu_ready}, 32'd1);
  endtask

  task automatic cpu_access(input logic rw, input logic [9:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, input bit keep);
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    exp_pb_rw      = rw;
    exp_pb_address = addr[7:2];
    exp_pb_wdata   = wdata;
    i_cpu_request  = 1'b1;
    i_cpu_rw       = rw;
    i_cpu_address  = addr;
    i_cpu_wdata    = wdata;
    start_cyc      = cyc;
    wait_cpu_ready();
    @(posedge clk);
    #1;
    if (!keep) i_cpu_request = 1'b0;
  endtask

  // Peripheral: `delay` cycles after its request is seen, raise ready for `hold` cycles.
  task automatic pb_respond(input int slot, input int delay, input int hold,
                            input logic [31:0] data);
    int t = 0;
    @(negedge clk);
    while (!o_pb_request[slot] && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!o_pb_request[slot]) begin
      check_eq("pb_request_bound", {28'd0, o_pb_request}, 32'd1 << slot);
      return;
    end
    repeat (delay) @(posedge clk);
    #1;
    i_pb_rdata = {4{~data}};
    i_pb_rdata[32*slot +: 32] = data;
    i_pb_ready[slot] = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    i_pb_ready = 4'b0000;
    i_pb_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1;
    i_cpu_request = 1'b0;
    i_cpu_rw = 1'b0;
    i_cpu_address = '0;
    i_cpu_wdata = '0;
    i_pb_ready = '0;
    i_pb_rdata = '0;
    exp_pb_rw = 1'b0;
    exp_pb_address = '0;
    exp_pb_wdata = '0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, o_cpu_ready}, 32'd0);
    check_eq("rst_error", {31'd0, o_cpu_error}, 32'd0);
    check_eq("rst_rdata", o_cpu_rdata, 32'd0);
    check_eq("rst_pb_request", {28'd0, o_pb_request}, 32'd0);
    check_eq("rst_pb_bus", {o_pb_rw, o_pb_address, 25'd0}, 32'd0);
    check_eq("rst_pb_wdata", o_pb_wdata, 32'd0);

    // Read slot 2 word 3, single-cycle ready one cycle after request.
    clear_counts();
    fork
      cpu_access(1'b0, 10'h20C, 32'h0, 32'h01312D00, 1'b0, 1'b0);
      pb_respond(2, 1, 1, 32'h01312D00);
    join
    check_eq("rd_pb_cycles_s2", pb_cycles[2], 1);
    check_eq("rd_pb_cycles_other", pb_cycles[0] + pb_cycles[1] + pb_cycles[3], 0);
    check_eq("rd_ready_count", rdy_count, 1);
    check_eq("rd_latency", ready_cyc - rise_cyc, 2);
    check_eq("rd_req_latency", rise_cyc - start_cyc, 1);

    // Write slot 1 word 1, peripheral holds ready three cycles.
    clear_counts();
    fork
      cpu_access(1'b1, 10'h104, 32'h000000A5, 32'h0, 1'b0, 1'b0);
      pb_respond(1, 1, 3, 32'h12345678);
    join
    repeat (3) @(posedge clk);
    #1;
    check_eq("wr_pb_cycles_s1", pb_cycles[1], 1);
    check_eq("wr_ready_count", rdy_count, 1);

    // Timeout on slot 0, then a late ready pulse that must be ignored.
    clear_counts();
    cpu_access(1'b0, 10'h000, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    check_eq("to_latency", ready_cyc - rise_cyc, 8);
    check_eq("to_pb_cycles_s0", pb_cycles[0], 8);
    @(posedge clk);
    #1;
    i_pb_ready[0] = 1'b1;
    i_pb_rdata = {4{32'h55AA55AA}};
    @(posedge clk);
    #1;
    i_pb_ready = 4'b0000;
    i_pb_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("to_late_ready_count", rdy_count, 1);

    // Unpopulated slot 3: immediate error response, no peripheral request.
    clear_counts();
    cpu_access(1'b0, 10'h3F0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    check_eq("unpop_latency", ready_cyc - start_cyc, 1);
    check_eq("unpop_pb_cycles", pb_cycles[0] + pb_cycles[1] + pb_cycles[2] + pb_cycles[3], 0);

    // Reset during WAIT abandons the access; a later ready is ignored.
    clear_counts();
    @(posedge clk);
    #1;
    exp_pb_rw = 1'b0;
    exp_pb_address = 6'd2;
    exp_pb_wdata = 32'h0;
    i_cpu_request = 1'b1;
    i_cpu_rw = 1'b0;
    i_cpu_address = 10'h108;
    i_cpu_wdata = 32'h0;
    @(posedge clk);
    #1;
    i_cpu_request = 1'b0;
    @(negedge clk);
    check_eq("rstw_pb_request", {28'd0, o_pb_request}, 32'h2);
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    last_rdata = 32'd0;
    @(negedge clk);
    check_eq("rstw_ready", {31'd0, o_cpu_ready}, 32'd0);
    check_eq("rstw_rdata", o_cpu_rdata, 32'd0);
    check_eq("rstw_pb_request", {28'd0, o_pb_request}, 32'd0);
    check_eq("rstw_pb_bus", {o_pb_rw, o_pb_address, 25'd0}, 32'd0);
    @(posedge clk);
    #1;
    i_pb_ready[1] = 1'b1;
    i_pb_rdata = {4{32'h13572468}};
    @(posedge clk);
    #1;
    i_pb_ready = 4'b0000;
    i_pb_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rstw_no_ready", rdy_count, 0);
    fork
      cpu_access(1'b0, 10'h108, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
      pb_respond(1, 2, 1, 32'h0BADF00D);
    join

    // Request held through RESP starts a second access; its ready lands on the timeout edge.
    clear_counts();
    fork
      cpu_access(1'b0, 10'h20C, 32'h0, 32'h11223344, 1'b0, 1'b1);
      pb_respond(2, 1, 1, 32'h11223344);
    join
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    fork
      pb_respond(2, 7, 1, 32'hCAFEF00D);
      wait_cpu_ready();
    join
    @(posedge clk);
    #1;
    i_cpu_request = 1'b0;
    check_eq("b2b_latency", ready_cyc - rise_cyc, 8);
    check_eq("b2b_ready_count", rdy_count, 2);
    check_eq("b2b_pb_cycles_s2", pb_cycles[2], 8);

    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
